alu_seq: RTL and testbench

- Parametrised, registered successor to the 8-bit combinational datapath ALU.
- Keeps the same eight opcodes and adds valid/ready handshakes on input and output, and a registered result with Z/N/C/V flags.
- Shifts become variable-distance and iterative: one bit per cycle.
- Sits between the instruction decode stage and the register-file write-back. Multi-cycle shifts stall the upstream stage through in_ready.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_core.sv | 62 ++++++
 rtl/alu_seq.sv | 98 +++++++++
 tb/tb_alu_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, the flag
// bundle and the signed-overflow helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_PASSA = 3'b000,
    OP_PASSB = 3'b001,
    OP_XOR   = 3'b010,
    OP_XNOR  = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_SHL   = 3'b110,
    OP_SHR   = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  // Subtraction is A + ~B + 1, so the effective B sign is inverted.
  function automatic logic signed_ovf(input logic sa, input logic sb,
                                      input logic sr, input logic sub);
    logic sb_eff;
    sb_eff = sub ? ~sb : sb;
    return (sa == sb_eff) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: single-cycle result/flags for non-shift
// opcodes (and zero-distance shifts) plus a one-bit shift step.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_e          op,
  input  logic [WIDTH-1:0] cur,
  input  logic             shr,
  output logic [WIDTH-1:0] res,
  output flags_t           flg,
  output logic [WIDTH-1:0] step_res,
  output flags_t           step_flg
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = '0;
    res = a;
    flg = '0;
    case (op)
      OP_PASSA: res = a;
      OP_PASSB: res = b;
      OP_XOR:   res = a ^ b;
      OP_XNOR:  res = ~(a ^ b);
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        res   = sum[WIDTH-1:0];
        flg.c = sum[WIDTH];
        flg.v = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        // The wrapped top bit of the extended difference is the borrow.
        sum   = {1'b0, a} - {1'b0, b};
        res   = sum[WIDTH-1:0];
        flg.c = sum[WIDTH];
        flg.v = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1], 1'b1);
      end
      default:  res = a;
    endcase
    flg.z = (res == '0);
    flg.n = res[WIDTH-1];
  end

  always_comb begin
    step_flg = '0;
    if (shr) begin
      step_res   = {1'b0, cur[WIDTH-1:1]};
      step_flg.c = cur[0];
    end else begin
      step_res   = {cur[WIDTH-2:0], 1'b0};
      step_flg.c = cur[WIDTH-1];
    end
    step_flg.z = (step_res == '0);
    step_flg.n = step_res[WIDTH-1];
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; shifts iterate one bit
// per cycle and stall upstream through in_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OPCode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  logic [SHW-1:0]   cnt;
  logic             shr_q;
  flags_t           flags_q;
  opcode_e          op;
  logic             is_shift;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] step_res;
  flags_t           flg;
  flags_t           step_flg;

  assign op        = opcode_e'(OPCode);
  assign is_shift  = (op == OP_SHL) || (op == OP_SHR);
  assign amt       = B[SHW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign flags     = flags_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (A),
    .b        (B),
    .op       (op),
    .cur      (ALU_Out),
    .shr      (shr_q),
    .res      (res),
    .flg      (flg),
    .step_res (step_res),
    .step_flg (step_flg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shr_q   <= 1'b0;
      ALU_Out <= '0;
      flags_q <= '0;
    end else if (clr) begin
      // Flush leaves the last result and flags visible on the outputs.
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (amt != '0)) begin
              ALU_Out <= A;
              cnt     <= amt;
              shr_q   <= (op == OP_SHR);
              state   <= BUSY;
            end else begin
              ALU_Out <= res;
              flags_q <= flg;
              state   <= DONE;
            end
          end
        end
        BUSY: begin
          ALU_Out <= step_res;
          cnt     <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            flags_q <= step_flg;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver pushes reference results into a
// queue on accept, a monitor compares whatever the DUT presents.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   OPCode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] ALU_Out;
  logic [3:0]   flags;

  int cmp = 0;
  int bad = 0;
  logic [11:0] expq[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .OPCode    (OPCode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Out   (ALU_Out),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {result, Z, N, C, V}.
  function automatic logic [11:0] model(input logic [2:0] op,
                                        input logic [7:0] a, input logic [7:0] b);
    int ai, bi, sa, sb, r, n, s;
    logic c, v;
    logic [7:0] res;
    ai = int'(a); bi = int'(b);
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    n = bi % 8;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      3'd0: r = ai;
      3'd1: r = bi;
      3'd2: r = ai ^ bi;
      3'd3: r = ~(ai ^ bi) & 255;
      3'd4: begin
        r = ai + bi; c = (r > 255);
        s = sa + sb; v = (s > 127) || (s < -128);
      end
      3'd5: begin
        r = ai - bi; c = (ai < bi);
        s = sa - sb; v = (s > 127) || (s < -128);
      end
      3'd6: begin
        r = ai << n; c = (n > 0) && (((ai >> (8 - n)) & 1) == 1);
      end
      default: begin
        r = ai >> n; c = (n > 0) && (((ai >> (n - 1)) & 1) == 1);
      end
    endcase
    res = r[7:0];
    return {res, (res == 8'h00), res[7], c, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      cmp++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %02h flags %04b with nothing pending at %0t",
                 ALU_Out, flags, $time);
      end else begin
        if ({ALU_Out, flags} !== expq[0]) begin
          bad++;
          $display("FAIL result: got %02h flags %04b expected %02h flags %04b at %0t",
                   ALU_Out, flags, expq[0][11:4], expq[0][3:0], $time);
        end
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  // Called 1 time unit after a posedge; returns 1 time unit after the accept edge.
  task automatic start(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      OPCode = op; A = a; B = b; in_valid = 1'b1;
      expq.push_back(model(op, a, b));
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = W'($urandom); B = W'($urandom); OPCode = 3'($urandom);
    end
  endtask

  task automatic complete_op(input int exp_busy, input int hold, input bit poke);
    int lat, ir_hi;
    lat = 0; ir_hi = 0;
    out_ready = (hold == 0);
    while (!out_valid && lat < 50) begin
      if (in_ready) ir_hi++;
      @(posedge clk); #1; lat++;
    end
    chk("busy_cycles", lat, exp_busy);
    chk("in_ready_low_while_busy", ir_hi, 0);
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        OPCode = 3'd4; A = 8'h11; B = 8'h22; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("held_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
  endtask

  function automatic int busy_of(input logic [2:0] op, input logic [7:0] b);
    return (op >= 3'd6) ? int'(b % 8) : 0;
  endfunction

  initial begin
    logic [2:0] op;
    logic [7:0] a, b;
    int hold;

    #12;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_alu_out", {24'd0, ALU_Out}, 32'd0);
    chk("reset_flags", {28'd0, flags}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan
    start(3'd4, 8'hFF, 8'h01); complete_op(0, 0, 1'b0);
    start(3'd5, 8'h80, 8'h01); complete_op(0, 0, 1'b0);
    start(3'd5, 8'h01, 8'h02); complete_op(0, 0, 1'b0);
    start(3'd6, 8'h81, 8'd3);  complete_op(3, 0, 1'b0);
    start(3'd7, 8'h81, 8'd1);  complete_op(1, 0, 1'b0);
    start(3'd6, 8'h81, 8'd0);  complete_op(0, 0, 1'b0);
    start(3'd3, 8'hF0, 8'h0F); complete_op(0, 5, 1'b1);

    // Asynchronous reset in the middle of a shift
    start(3'd7, 8'hFF, 8'd7);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_alu_out", {24'd0, ALU_Out}, 32'd0);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midreset_flags", {28'd0, flags}, 32'd0);
    expq.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    start(3'd4, 8'h02, 8'h03); complete_op(0, 0, 1'b0);

    // Synchronous flush during a long shift
    start(3'd6, 8'h5A, 8'd6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    expq.delete();
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("clr_stays_idle", {31'd0, out_valid}, 32'd0);
    start(3'd1, 8'h3C, 8'hA5); complete_op(0, 0, 1'b0);

    // Randomised traffic
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      hold = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      start(op, a, b);
      complete_op(busy_of(op, b), hold, 1'(k % 7 == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
